// File: rtl/nibble_add_seq.sv
// nibble_add_seq: wide add/subtract sequenced LSB-first, one nibble per clock, over an external 4-bit adder slice.
// Optional signed-overflow flag is built when NIBBLE_ADD_SEQ_OVF_EN is defined; otherwise ovf is tied to 0.
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   ovf,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   a_reg, b_reg;
  logic           sub_reg;
  logic [IW-1:0]  idx;
  logic [IW+1:0]  base;
  logic           carry_reg;
  logic           accept;
  logic           last;

  assign base = {idx, 2'b00};
  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // The adder ports carry the current nibble only while running, and are parked at 0 otherwise.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    add_a    = 4'h0;
    add_b    = 4'h0;
    add_cin  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = a_reg[base +: 4];
        add_b   = sub_reg ? ~b_reg[base +: 4] : b_reg[base +: 4];
        add_cin = carry_reg;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1, so the carry register is seeded with sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      idx       <= '0;
      carry_reg <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a_reg     <= op_a;
      b_reg     <= op_b;
      sub_reg   <= sub;
      idx       <= '0;
      carry_reg <= sub;
    end else if (state == RUN) begin
      result[base +: 4] <= add_sum;
      carry_reg         <= add_cout;
      if (last) begin
        idx       <= '0;
        carry_out <= add_cout;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef NIBBLE_ADD_SEQ_OVF_EN
  logic msb_cin;

  // Carry into the MSB is recovered from the slice's own MSB sum bit.
  assign msb_cin = add_a[3] ^ add_b[3] ^ add_sum[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    ovf <= 1'b0;
    else if (state == RUN && last) ovf <= msb_cin ^ add_cout;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
